// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes and exec FSM state type.
package alu_pkg;
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle serial shifter with down-counting shift amount.
module alu_shift_iter #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               step_i,
   input  logic               right_i,
   input  logic [XLEN-1:0]    din_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               last_o,
   output logic [XLEN-1:0]    dout_o
);
   logic [XLEN-1:0]    acc_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               right_q;
   assign dout_o = right_q ? acc_q >> 1 : acc_q << 1;
   assign last_o = cnt_q == SHAMT_W'(1);
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         right_q <= 1'b0;
      end else if (start_i) begin
         acc_q   <= din_i;
         cnt_q   <= shamt_i;
         right_q <= right_i;
      end else if (step_i) begin
         acc_q <= dout_o;
         cnt_q <= cnt_q - SHAMT_W'(1);
      end
   end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: handshaked ALU; shifts run serially, everything else completes in one cycle.
module alu_exec
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alucontrol,
   input  logic [XLEN-1:0] srca,
   input  logic [XLEN-1:0] srcb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);
   state_t             state_q, state_d;
   logic [XLEN-1:0]    result_q, result_d, alu_y, sh_nxt;
   logic               zero_q, zero_d, accept, start, last;
   logic [SHAMT_W-1:0] shamt;
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign result    = result_q;
   assign zero      = zero_q;
   assign accept    = in_valid && in_ready;
   assign shamt     = srcb[SHAMT_W-1:0];
   assign start     = accept && (alucontrol == ALU_SLL || alucontrol == ALU_SRL) && shamt != '0;
   // Shift ops only reach alu_y with a zero shift amount, so they pass srca through.
   always_comb begin
      case (alucontrol)
         ALU_SUB: alu_y = srca - srcb;
         ALU_AND: alu_y = srca & srcb;
         ALU_OR:  alu_y = srca | srcb;
         ALU_XOR: alu_y = srca ^ srcb;
         ALU_SLL: alu_y = srca;
         ALU_SRL: alu_y = srca;
         ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
         default: alu_y = srca + srcb;
      endcase
   end
   alu_shift_iter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
      .clk     (clk),
      .reset   (reset),
      .start_i (start),
      .step_i  (state_q == SHIFT),
      .right_i (alucontrol == ALU_SRL),
      .din_i   (srca),
      .shamt_i (shamt),
      .last_o  (last),
      .dout_o  (sh_nxt)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? (start ? SHIFT : DONE) : IDLE;
         SHIFT:   state_d = last ? DONE : SHIFT;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      result_d = (accept && !start) ? alu_y : (state_q == SHIFT && last) ? sh_nxt : result_q;
      zero_d   = result_d == '0;
   end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: XLEN, 32, operand/result width.
REQ-002 Parameter: SHAMT_W, 5, shift-amount width (log2 XLEN).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 alucontrol  input  4  op code from the ALU decoder.
REQ-008 srca  input  XLEN  operand A.
REQ-009 srcb  input  XLEN  operand B; bits [SHAMT_W-1:0] are the shift amount.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  registered result.
REQ-013 zero  output  1  registered flag, 1 when result==0.

Function
REQ-014 Op codes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL (logical), 0111 SLT (signed); codes 1000-1111 SHALL execute as ADD.
REQ-015 ADD/SUB SHALL wrap modulo 2^XLEN; SLT result SHALL be 1 if signed(srca)<signed(srcb), else 0, zero-extended.
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept = in_valid && in_ready; operands and op SHALL be captured only on accept.
REQ-018 IDLE, accept, non-shift op or shift with shamt 0: result/zero registered at that edge, next state DONE (latency 1 cycle).
REQ-019 IDLE, accept, SLL/SRL with shamt k>0: accumulator<=srca, counter<=k, next state SHIFT.
REQ-020 SHIFT: each cycle accumulator shifts 1 bit (SLL left, SRL right, zero fill), counter decrements; on the cycle counter==1 the final shifted value SHALL load result/zero and state SHALL go to DONE (latency k+1 cycles from accept).
REQ-021 SHIFT SHALL ignore in_valid and out_ready.
REQ-022 DONE: out_valid=1; result/zero SHALL hold stable until out_ready; out_valid && out_ready SHALL return to IDLE next cycle.
REQ-023 No new request SHALL be accepted in the DONE->IDLE handoff cycle (max throughput one op per 2 cycles).
REQ-024 Shift amount SHALL use only srcb[SHAMT_W-1:0]; upper srcb bits ignored for shifts.

Reset
REQ-025 While reset=1 at a clock edge: state<=IDLE, out_valid<=0, result<=0, zero<=1, counter<=0, accumulator<=0.
REQ-026 Reset asserted in SHIFT or DONE SHALL discard the in-flight operation with no out_valid pulse.
REQ-027 reset SHALL take priority over every handshake event in the same cycle.

Structure
REQ-028 Package alu_pkg SHALL hold the alucontrol code constants and the FSM state type; the ALU decoder SHALL use the same constants.
REQ-029 Serial shifter (accumulator, counter, direction) SHALL be one sub-module, alu_shift_iter; remaining ops stay in alu_exec.

Verification
REQ-030 ADD 0x7FFFFFFF+0x00000001 -> out_valid 1 cycle after accept, result 0x80000000, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-031 SLT srca=0xFFFFFFFF, srcb=1 -> result 1; SLT srca=1, srcb=0xFFFFFFFF -> result 0.
REQ-032 SRL srca=0x80000000, srcb=0x0000001F -> out_valid exactly 32 cycles after accept, result 0x00000001; SLL srcb=0 -> 1-cycle latency, result=srca.
REQ-033 out_ready held 0 for 10 cycles in DONE -> result/out_valid stable, in_ready 0; in_valid pulsed during SHIFT -> not accepted.
REQ-034 reset asserted mid-SHIFT (SLL by 20, cycle 5) -> next cycle IDLE, in_ready 1, out_valid 0, result 0; following ADD 2+3 -> result 5.
REQ-035 alucontrol 1010, srca=3, srcb=4 -> result 7 (ADD fallback).
